panel_load_sequencer: RTL and testbench
=======================================

Name: panel_load_sequencer

Overview:
- Controller that loads a selected program image into Altair memory by driving the machine's front-panel switch inputs, as a user would: stop, set address, examine, then deposit/deposit-next per byte, optionally run.
- Sits between the program-select menu and the inputs of `front_panel_mapping`/`altair`. It replaces the hand-toggled switches while it is busy.
- Reads image bytes from an external ROM port with 1-cycle latency.

Parameters:
- PULSE_CYCLES, 16: cycles a momentary switch (examine/deposit/deposit_next) is held high.
- GAP_CYCLES, 16: settle cycles after each switch change and after each pulse release.
- LEN_WIDTH, 16: width of the byte count and byte index.

Ports:
- clk  in  1  system clock, the same domain as the `altair` machine clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  1-cycle request to begin a load. Ignored while busy.
- abort  in  1  level; cancels an in-progress load.
- base_addr  in  16  target memory address of image byte 0.
- prog_len  in  LEN_WIDTH  number of bytes to load.
- auto_run  in  1  1 = release stop after the load.
- img_addr  out  LEN_WIDTH  image byte index.
- img_rd  out  1  read strobe.
- img_data  in  8  byte for img_addr, valid the cycle after img_rd.
- busy  out  1  high from the cycle after an accepted start until done/abort.
- done  out  1  1-cycle pulse at successful completion.
- pause_sw  out  1  stop/run switch (1 = stop).
- addr_sense_sw  out  8  high address switches.
- data_addr_sw  out  8  low address/data switches.
- examine_sw  out  1  momentary examine switch.
- deposit_sw  out  1  momentary deposit switch.
- deposit_next_sw  out  1  momentary deposit-next switch.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State IDLE; all outputs 0, including pause_sw; index 0; timer 0.
- Single down-counter timer:
  - WAIT_n: load n-1, hold state until the timer reaches 0.
  - Every switch-driving state holds its outputs stable for its full duration.
- State sequence:
  - IDLE: on start=1, latch base_addr, prog_len and auto_run; go to STOP.
  - STOP: pause_sw=1; wait GAP_CYCLES.
  - SET_ADDR: addr_sense_sw=base[15:8], data_addr_sw=base[7:0]; wait GAP_CYCLES.
  - EXAMINE: examine_sw=1 for PULSE_CYCLES, then 0 and wait GAP_CYCLES.
  - If latched len==0, go to FINISH; else index=0 and go to FETCH.
  - FETCH: img_addr=index, img_rd=1 for exactly 1 cycle; next cycle (CAPTURE) register img_data.
  - SET_DATA: data_addr_sw=captured byte; addr_sense_sw is unchanged; wait GAP_CYCLES.
  - DEPOSIT: pulse deposit_sw if index==0, else deposit_next_sw, for PULSE_CYCLES. Release, wait GAP_CYCLES. index += 1.
  - If index==len go to FINISH, else go to FETCH.
  - FINISH, auto_run=1: re-run SET_ADDR/EXAMINE for base_addr (sets PC), then pause_sw=0. auto_run=0: pause_sw stays 1.
  - FINISH then pulses done for 1 cycle, clears busy, returns to IDLE.
- Switch exclusivity: at most one of examine_sw, deposit_sw, deposit_next_sw is high in any cycle. There is a GAP_CYCLES gap between any two pulses.
- Address wrap: the machine increments the address; base_addr+len beyond 0xFFFF wraps in the machine. The block does no address arithmetic beyond the index.
- start while busy: ignored, with no effect on the latched values.
- start and abort together in IDLE: abort wins; no load starts.
- abort while busy:
  - Next cycle: state IDLE, busy=0, every momentary switch output=0, img_rd=0, done not pulsed.
  - pause_sw keeps its current value, so the machine stays stopped mid-load.
- Reset mid-load: same as the reset values, including pause_sw=0.
- Latency with PULSE=P, GAP=G, len=N≥1:
  - start to done = 1 + 3G + P + N(2 + 2G + P), plus 2G + P + G if auto_run.
  - Timing checked to ±1 cycle of the state entry.
- In IDLE, pause_sw, addr_sense_sw and data_addr_sw hold their last driven values.

Test Plan:
- P=4, G=4, base=0x0000, len=3, image {0xC3,0x00,0x00}, auto_run=0 -> pause_sw=1; one examine pulse with switches 0x00/0x00; deposit pulse with data 0xC3; two deposit_next pulses with 0x00, 0x00; done once; busy 0 afterwards; pause_sw stays 1. A behavioural `altair` model reads mem[0..2]=C3 00 00.
- base=0x1234, len=2, auto_run=1 -> first examine with addr_sense_sw=0x12, data_addr_sw=0x34; second examine with the same switches after the deposits; pause_sw falls to 0 exactly 1 cycle before done.
- len=0, auto_run=0 -> STOP and one examine, no img_rd, no deposit pulses, done pulses.
- abort held 1 cycle during the second deposit_next pulse -> next cycle deposit_next_sw=0, busy=0, no done, pause_sw=1. A new start then runs a full load correctly.
- start pulsed again while busy, with a different base_addr -> ignored; the load completes with the original base.
- reset=0 asserted mid-FETCH -> all outputs 0 next edge; img_rd never high for 2 consecutive cycles across the whole test.

Source files
------------

// File: rtl/panel_load_sequencer.sv
// Drives the Altair front-panel switches to load a program image byte by byte:
// stop, set address, examine, then deposit / deposit-next per byte, optionally run.
module panel_load_sequencer #(
  parameter int unsigned PULSE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          base_addr,
  input  logic [LEN_WIDTH-1:0] prog_len,
  input  logic                 auto_run,
  output logic [LEN_WIDTH-1:0] img_addr,
  output logic                 img_rd,
  input  logic [7:0]           img_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pause_sw,
  output logic [7:0]           addr_sense_sw,
  output logic [7:0]           data_addr_sw,
  output logic                 examine_sw,
  output logic                 deposit_sw,
  output logic                 deposit_next_sw
);

  typedef enum logic [3:0] {
    StIdle, StStop, StSetAddr, StExPulse, StExGap, StFetch, StCapture,
    StSetData, StDepPulse, StDepGap, StRun, StFinish
  } state_e;

  localparam logic [15:0] PulseLoad = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GapLoad   = 16'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic [15:0]          base_q, base_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  logic                 auto_run_q, auto_run_d;
  logic                 run_phase_q, run_phase_d;
  logic                 pause_q, pause_d;
  logic [7:0]           addr_hi_q, addr_hi_d;
  logic [7:0]           data_q, data_d;
  logic                 timer_done;
  logic                 load_end;
  logic [LEN_WIDTH-1:0] idx_inc;

  assign timer_done = (timer_q == 16'd0);
  assign idx_inc    = idx_q + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      auto_run_q  <= 1'b0;
      run_phase_q <= 1'b0;
      pause_q     <= 1'b0;
      addr_hi_q   <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      auto_run_q  <= auto_run_d;
      run_phase_q <= run_phase_d;
      pause_q     <= pause_d;
      addr_hi_q   <= addr_hi_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_done ? 16'd0 : timer_q - 16'd1;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    auto_run_d  = auto_run_q;
    run_phase_d = run_phase_q;
    pause_d     = pause_q;
    addr_hi_d   = addr_hi_q;
    data_d      = data_q;
    load_end    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          base_d      = base_addr;
          len_d       = prog_len;
          auto_run_d  = auto_run;
          run_phase_d = 1'b0;
          pause_d     = 1'b1;
          timer_d     = GapLoad;
          state_d     = StStop;
        end
      end
      StStop: begin
        if (timer_done) begin
          addr_hi_d = base_q[15:8];
          data_d    = base_q[7:0];
          timer_d   = GapLoad;
          state_d   = StSetAddr;
        end
      end
      StSetAddr: begin
        if (timer_done) begin
          timer_d = PulseLoad;
          state_d = StExPulse;
        end
      end
      StExPulse: begin
        if (timer_done) begin
          timer_d = GapLoad;
          state_d = StExGap;
        end
      end
      StExGap: begin
        if (timer_done) begin
          if (run_phase_q) begin
            timer_d = GapLoad;
            state_d = StRun;
            // With a single-cycle run phase the stop switch must drop on entry.
            if (GAP_CYCLES <= 1) pause_d = 1'b0;
          end else if (len_q == '0) begin
            load_end = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: state_d = StCapture;
      StCapture: begin
        data_d  = img_data;
        timer_d = GapLoad;
        state_d = StSetData;
      end
      StSetData: begin
        if (timer_done) begin
          timer_d = PulseLoad;
          state_d = StDepPulse;
        end
      end
      StDepPulse: begin
        if (timer_done) begin
          timer_d = GapLoad;
          state_d = StDepGap;
        end
      end
      StDepGap: begin
        if (timer_done) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) load_end = 1'b1;
          else                  state_d  = StFetch;
        end
      end
      StRun: begin
        // Release stop for the final cycle so the machine runs just before done.
        if (timer_q == 16'd1) pause_d = 1'b0;
        if (timer_done) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // End of image: either re-examine base to set the PC, or finish stopped.
    if (load_end) begin
      if (auto_run_q) begin
        run_phase_d = 1'b1;
        addr_hi_d   = base_q[15:8];
        data_d      = base_q[7:0];
        timer_d     = GapLoad;
        state_d     = StSetAddr;
      end else begin
        state_d = StFinish;
      end
    end

    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      timer_d     = '0;
      run_phase_d = 1'b0;
      pause_d     = pause_q;
      addr_hi_d   = addr_hi_q;
      data_d      = data_q;
      idx_d       = idx_q;
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StFinish);
  assign img_rd          = (state_q == StFetch);
  assign img_addr        = idx_q;
  assign pause_sw        = pause_q;
  assign addr_sense_sw   = addr_hi_q;
  assign data_addr_sw    = data_q;
  assign examine_sw      = (state_q == StExPulse);
  assign deposit_sw      = (state_q == StDepPulse) && (idx_q == '0);
  assign deposit_next_sw = (state_q == StDepPulse) && (idx_q != '0);

endmodule

// File: tb/tb_panel_load_sequencer.sv
// Directed bench for panel_load_sequencer: scoreboard of expected switch events,
// a ROM model and a behavioural Altair memory model.
module tb_panel_load_sequencer;
  localparam int unsigned P  = 4;
  localparam int unsigned G  = 4;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          auto_run = 1'b0;
  logic [15:0]   base_addr = '0;
  logic [LW-1:0] prog_len = '0;
  logic [LW-1:0] img_addr;
  logic          img_rd;
  logic [7:0]    img_data = '0;
  logic          busy, done, pause_sw;
  logic [7:0]    addr_sense_sw, data_addr_sw;
  logic          examine_sw, deposit_sw, deposit_next_sw;

  panel_load_sequencer #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .prog_len       (prog_len),
    .auto_run       (auto_run),
    .img_addr       (img_addr),
    .img_rd         (img_rd),
    .img_data       (img_data),
    .busy           (busy),
    .done           (done),
    .pause_sw       (pause_sw),
    .addr_sense_sw  (addr_sense_sw),
    .data_addr_sw   (data_addr_sw),
    .examine_sw     (examine_sw),
    .deposit_sw     (deposit_sw),
    .deposit_next_sw(deposit_next_sw)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  logic [31:0] exp_q[$];

  logic [7:0] rom [0:15];
  logic [7:0] mem [0:65535];
  logic [15:0] am_addr = '0;

  int rd_cnt = 0, rd_double = 0, excl_viol = 0, gap_viol = 0;
  int dn_cnt = 0, done_cnt = 0, done_cyc = 0, pause_fall_cyc = 0, last_fall_cyc = -1000;
  logic prev_ex = 0, prev_dep = 0, prev_dn = 0, prev_rd = 0, prev_pause = 0;
  logic m_ex = 0, m_dep = 0, m_dn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input logic [31:0] ev);
    logic [31:0] e;
    if (exp_q.size() == 0) e = 32'hFFFF_FFFF;
    else e = exp_q.pop_front();
    check("scoreboard", ev, e);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (img_rd) img_data <= rom[img_addr[3:0]];
  end

  // Altair memory model reacting to switch rising edges.
  always @(posedge clk) begin
    if (examine_sw && !m_ex) am_addr = {addr_sense_sw, data_addr_sw};
    if (deposit_sw && !m_dep) mem[am_addr] = data_addr_sw;
    if (deposit_next_sw && !m_dn) begin
      am_addr = am_addr + 16'd1;
      mem[am_addr] = data_addr_sw;
    end
    m_ex = examine_sw;
    m_dep = deposit_sw;
    m_dn = deposit_next_sw;
  end

  always @(negedge clk) begin
    if (examine_sw && !prev_ex) sb_check({8'd1, addr_sense_sw, data_addr_sw, 8'd0});
    if (deposit_sw && !prev_dep) sb_check({8'd2, addr_sense_sw, data_addr_sw, 8'd0});
    if (deposit_next_sw && !prev_dn) begin
      sb_check({8'd3, addr_sense_sw, data_addr_sw, 8'd0});
      dn_cnt++;
    end
    if ((examine_sw && !prev_ex) || (deposit_sw && !prev_dep) || (deposit_next_sw && !prev_dn))
      if (cyc - last_fall_cyc < int'(G)) gap_viol++;
    if ((!examine_sw && prev_ex) || (!deposit_sw && prev_dep) || (!deposit_next_sw && prev_dn))
      last_fall_cyc = cyc;
    if (done) begin
      sb_check({8'd4, 16'd0, 7'd0, pause_sw});
      done_cnt++;
      done_cyc = cyc;
    end
    if (img_rd) rd_cnt++;
    if (img_rd && prev_rd) rd_double++;
    if (int'(examine_sw) + int'(deposit_sw) + int'(deposit_next_sw) > 1) excl_viol++;
    if (prev_pause && !pause_sw) pause_fall_cyc = cyc;
    prev_ex = examine_sw;
    prev_dep = deposit_sw;
    prev_dn = deposit_next_sw;
    prev_rd = img_rd;
    prev_pause = pause_sw;
  end

  function automatic int lat(input int n, input bit ar);
    return 1 + 3 * G + P + n * (2 + 2 * G + P) + (ar ? (3 * G + P) : 0);
  endfunction

  task automatic push_load(input logic [15:0] b, input int n, input bit ar);
    exp_q.push_back({8'd1, b[15:8], b[7:0], 8'd0});
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == 0) ? 8'd2 : 8'd3, b[15:8], rom[i], 8'd0});
    if (ar) exp_q.push_back({8'd1, b[15:8], b[7:0], 8'd0});
    exp_q.push_back({8'd4, 16'd0, 7'd0, !ar});
  endtask

  task automatic start_load(input logic [15:0] b, input int n, input bit ar);
    @(negedge clk);
    base_addr = b;
    prog_len = LW'(n);
    auto_run = ar;
    start = 1'b1;
    push_load(b, n, ar);
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic finish_load(input string tag, input int n, input bit ar);
    int k;
    while (!done && (cyc - t0) < 3000) begin
      @(posedge clk);
      #1;
    end
    k = cyc - t0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_latency_ok"}, ((k >= lat(n, ar) - 1) && (k <= lat(n, ar) + 1)), 1);
    @(posedge clk);
    #1;
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int k;
    int c0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {busy, done, pause_sw, addr_sense_sw, data_addr_sw, examine_sw, deposit_sw,
           deposit_next_sw, img_rd, img_addr[6:0]}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Load 1: base 0, three bytes, stay stopped.
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    rom[0] = 8'hC3; rom[1] = 8'h00; rom[2] = 8'h00;
    start_load(16'h0000, 3, 1'b0);
    check("t1_busy", busy, 1'b1);
    finish_load("t1", 3, 1'b0);
    check("t1_pause", pause_sw, 1'b1);
    check("t1_mem", {mem[0], mem[1], mem[2]}, 24'hC30000);
    check("t1_done_cnt", done_cnt, 1);

    // Load 2: auto-run re-examines base, pause drops one cycle before done.
    rom[0] = 8'hAA; rom[1] = 8'h55;
    start_load(16'h1234, 2, 1'b1);
    finish_load("t2", 2, 1'b1);
    check("t2_pause_fall", done_cyc - pause_fall_cyc, 1);
    check("t2_pause", pause_sw, 1'b0);
    check("t2_mem", {mem[16'h1234], mem[16'h1235]}, 16'hAA55);

    // Load 3: zero length, no reads.
    c0 = rd_cnt;
    start_load(16'h0050, 0, 1'b0);
    finish_load("t3", 0, 1'b0);
    check("t3_no_reads", rd_cnt - c0, 0);

    // Load 4: abort during the second deposit-next pulse.
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h03; rom[3] = 8'h04;
    c0 = done_cnt;
    dn_cnt = 0;
    start_load(16'h0100, 4, 1'b0);
    k = 0;
    while (dn_cnt < 2 && k < 2000) begin
      @(posedge clk);
      #1 k++;
    end
    check("t4_dn_reached", dn_cnt, 2);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("t4_abort_outputs", {deposit_next_sw, deposit_sw, examine_sw, img_rd, busy, done},
          6'b0);
    check("t4_abort_pause", pause_sw, 1'b1);
    check("t4_pending", exp_q.size(), 2);
    exp_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check("t4_no_done", done_cnt - c0, 0);
    check("t4_mem_partial", {mem[16'h0100], mem[16'h0101], mem[16'h0102]}, 24'h010203);

    // Load 5: full load after abort, with a stray start mid-load.
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33;
    mem[16'hBEEF] = 8'h5A;
    start_load(16'h0300, 3, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    base_addr = 16'hBEEF;
    prog_len = LW'(7);
    auto_run = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_load("t5", 3, 1'b0);
    check("t5_mem", {mem[16'h0300], mem[16'h0301], mem[16'h0302]}, 24'h112233);
    check("t5_untouched", mem[16'hBEEF], 8'h5A);
    check("t5_pause", pause_sw, 1'b1);

    // Load 6: reset during FETCH.
    start_load(16'h0400, 3, 1'b0);
    k = 0;
    while (!img_rd && k < 2000) begin
      @(posedge clk);
      #1 k++;
    end
    check("t6_fetch_seen", img_rd, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t6_reset_outputs",
          {busy, done, pause_sw, addr_sense_sw, data_addr_sw, examine_sw, deposit_sw,
           deposit_next_sw, img_rd, img_addr[6:0]}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    check("rd_never_double", rd_double, 0);
    check("switch_exclusive", excl_viol, 0);
    check("pulse_gap", gap_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
